gamepad_dev: RTL and testbench
==============================

Name: gamepad_dev

Overview:
- Device-side emulation of an NES/SNES-style serial gamepad, i.e. the controller end of the latch/clock/data protocol driven by the console/host reader.
- Samples the asynchronous pad_latch/pad_clk pins, snapshots button state on latch, and shifts one bit per clock onto DATA_WIDTH parallel data lines.
- Button state comes from a register-level input, so a soft core or a USB bridge can act as one or more controllers.

Parameters:
- DATA_WIDTH, 2, number of parallel data lines; each line carries an independent 16-bit controller.
- SYNC_STAGES, 2, flip-flop synchronizer depth on pad_latch/pad_clk; minimum 2.
- FILT_LEN, 3, glitch filter length: consecutive cycles a synchronized level must persist before it is accepted; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pad_latch  in  1  host latch pin, async, active-high
- pad_clk  in  1  host clock pin, async, idles high
- pad_data  out  DATA_WIDTH  serial data to host, active-low (0 = pressed)
- btn_value  in  16*DATA_WIDTH  button state, active-high (1 = pressed); line k uses bits [16k+:16], bit 0 is sent first
- ctrl_en  in  1  1 = respond to host; 0 = disconnected behaviour
- stat_frame  out  1  one-cycle pulse on each accepted latch falling edge
- stat_snapshot  out  16*DATA_WIDTH  btn_value captured at the last latch falling edge
- stat_clk_cnt  out  6  pad_clk rising edges since the last latch fall, saturating at 63

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all shift regs = 16'hFFFF; pad_data all 1.
  - stat_frame = 0; stat_snapshot = 0; stat_clk_cnt = 0.
  - Filter outputs = latch 0, clk 1; filter counters = 0.
- Input conditioning, per pin:
  - SYNC_STAGES-flop synchronizer produces s.
  - Filter register f with counter c: if s == f then c <= 0; else if c == FILT_LEN-1 then f <= s and c <= 0; else c <= c+1.
  - Edges: rise = f & ~f_d, fall = ~f & f_d, where f_d is f delayed one cycle.
- Shift regs: one 16-bit register per line; pad_data[k] = sr[k][0].
- FSM:
  - IDLE: if ctrl_en & latch_f, go to LOAD.
  - LOAD:
    - Every cycle, sr[k] <= ~btn_value[16k+:16]; pad_data therefore tracks live buttons while latch is high.
    - On latch fall: go to SHIFT, stat_snapshot <= btn_value, stat_frame <= 1, stat_clk_cnt <= 0.
  - SHIFT:
    - On clk rise: sr[k] <= {1'b1, sr[k][15:1]}; stat_clk_cnt <= min(cnt+1, 63).
    - After 16 rises, pad_data stays 1 (released) for further clocks.
    - On latch rise: go to LOAD (abort mid-frame, no error).
  - Any state with ctrl_en = 0: force IDLE next cycle, sr = 16'hFFFF, pad_data all 1; stat_* hold their values (stat_frame forced 0).
- Simultaneous events:
  - clk rise while latch_f is high is ignored; reload wins.
  - clk rise in the same cycle as latch fall is ignored; no shift on that cycle.
  - Latch rise and clk rise in the same cycle in SHIFT: latch wins.
- Latency:
  - Raw pin edge to pad_data change: SYNC_STAGES + FILT_LEN + 1 cycles, ±1 for sampling phase.
  - With defaults, 6 ±1 cycles. The host half-period must exceed this; at 150 clocks per tick there is ample margin.
- Glitches shorter than FILT_LEN cycles (after sync) never produce edges.
- Reset mid-frame: outputs go to reset values immediately; the next frame starts at the next latch high.

Test Plan:
- Reset, ctrl_en = 1, btn_value line0 = 16'h0005, line1 = 16'h8000; latch pulse then 16 clocks, sampled before each clk falls -> line0 bits 0,1,0,1,1,… (0 at positions 0 and 2), line1 0 only at bit 15; stat_frame pulses once; stat_snapshot = {16'h8000,16'h0005}; stat_clk_cnt = 16.
- Same frame with 20 clocks -> bits 16..19 read 1 on both lines; stat_clk_cnt = 20. A 70-clock frame -> stat_clk_cnt = 63.
- Latch high, change btn_value 0 -> 1 while held -> pad_data[0] falls within 1 cycle; pad_clk pulses during latch cause no shift and no count.
- Latch re-asserted after 5 clocks, new btn_value 16'h0002 -> reload; the next frame reads bit1 = 0 from bit 0 onward, with no residue from the aborted frame.
- Pin glitches of 1–2 cycles on pad_clk/pad_latch (FILT_LEN = 3) -> no shift, no stat_frame; a 3-cycle-stable change is accepted.
- ctrl_en dropped mid-frame -> pad_data all 1 within 2 cycles and stat_* frozen; re-enable plus a new latch -> normal frame. rst_n asserted mid-shift -> outputs at reset values immediately, without needing a clk edge.

Source files
------------

// File: rtl/gamepad_dev.sv
// gamepad_dev - device end of an NES/SNES-style latch/clock/data gamepad link.
//
// The host drives pad_latch and pad_clk asynchronously; both pins are
// synchronized and glitch-filtered before use. On latch the live button state
// is loaded into one 16-bit shift register per data line. Each accepted
// pad_clk rising edge then shifts out the next bit, LSB first, active-low.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   pad_latch       host latch pin (async, active-high)
//   pad_clk         host clock pin (async, idles high)
//   pad_data        serial data per line to the host (active-low, 0 = pressed)
//   btn_value       button state, 16 bits per line, 1 = pressed, bit 0 first
//   ctrl_en         1 = respond to host, 0 = behave as an unplugged pad
//   stat_frame      one-cycle pulse on each accepted latch falling edge
//   stat_snapshot   btn_value captured at the last latch falling edge
//   stat_clk_cnt    pad_clk rises since the last latch fall, saturating at 63
module gamepad_dev #(
  parameter int unsigned DATA_WIDTH  = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pad_latch,
  input  logic                       pad_clk,
  output logic [DATA_WIDTH-1:0]      pad_data,
  input  logic [16*DATA_WIDTH-1:0]   btn_value,
  input  logic                       ctrl_en,
  output logic                       stat_frame,
  output logic [16*DATA_WIDTH-1:0]   stat_snapshot,
  output logic [5:0]                 stat_clk_cnt
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Synchronizers: latch idles low, clk idles high.
  logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;

  // Filter state, index 0 = latch, index 1 = clk.
  logic [1:0]         s;
  logic [1:0]         f_q, f_d;
  logic [1:0]         fd_q, fd_d;
  logic [1:0][CW-1:0] c_q, c_d;

  logic latch_f, latch_rise, latch_fall, clk_rise;

  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0][15:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0][15:0] btn_arr;
  logic                        frame_q, frame_d;
  logic [16*DATA_WIDTH-1:0]    snap_q, snap_d;
  logic [5:0]                  cnt_q, cnt_d;

  assign btn_arr = btn_value;

  always_comb begin
    lat_sync_d = {lat_sync_q[SYNC_STAGES-2:0], pad_latch};
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
    s          = {clk_sync_q[SYNC_STAGES-1], lat_sync_q[SYNC_STAGES-1]};
  end

  // A new level is adopted only after it has differed from the filtered
  // value for FILT_LEN consecutive cycles; any return resets the count.
  always_comb begin
    f_d  = f_q;
    c_d  = c_q;
    fd_d = f_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (s[i] == f_q[i]) begin
        c_d[i] = '0;
      end else if (c_q[i] == CW'(FILT_LEN - 1)) begin
        f_d[i] = s[i];
        c_d[i] = '0;
      end else begin
        c_d[i] = c_q[i] + CW'(1);
      end
    end
  end

  assign latch_f    = f_q[0];
  assign latch_rise = f_q[0] & ~fd_q[0];
  assign latch_fall = ~f_q[0] & fd_q[0];
  assign clk_rise   = f_q[1] & ~fd_q[1];

  // Latch handling is checked before clk in every state, so a clk rise
  // coinciding with a latch edge or a held latch never shifts.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    frame_d = 1'b0;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    if (!ctrl_en) begin
      state_d = IDLE;
      sr_d    = '1;
    end else begin
      case (state_q)
        IDLE: begin
          sr_d = '1;
          if (latch_f) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            sr_d[k] = ~btn_arr[k];
          end
          if (latch_fall) begin
            state_d = SHIFT;
            snap_d  = btn_value;
            frame_d = 1'b1;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (latch_rise) begin
            state_d = LOAD;
          end else if (clk_rise) begin
            for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
              sr_d[k] = {1'b1, sr_q[k][15:1]};
            end
            if (cnt_q != 6'd63) begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          sr_d    = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sync_q <= '0;
      clk_sync_q <= '1;
      f_q        <= 2'b10;
      fd_q       <= 2'b10;
      c_q        <= '0;
      state_q    <= IDLE;
      sr_q       <= '1;
      frame_q    <= 1'b0;
      snap_q     <= '0;
      cnt_q      <= '0;
    end else begin
      lat_sync_q <= lat_sync_d;
      clk_sync_q <= clk_sync_d;
      f_q        <= f_d;
      fd_q       <= fd_d;
      c_q        <= c_d;
      state_q    <= state_d;
      sr_q       <= sr_d;
      frame_q    <= frame_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    pad_data = '1;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      pad_data[k] = sr_q[k][0];
    end
  end

  assign stat_frame    = frame_q;
  assign stat_snapshot = snap_q;
  assign stat_clk_cnt  = cnt_q;

endmodule

// File: tb/tb_gamepad_dev.sv
// Testbench for gamepad_dev: table-driven frames, hand-written corner
// sequences, and random frames checked against a bit-level protocol model.
module tb_gamepad_dev;

  localparam int PH = 12;  // host pin phase length in system clocks

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pad_latch;
  logic        pad_clk;
  logic [1:0]  pad_data;
  logic [31:0] btn_value;
  logic        ctrl_en;
  logic        stat_frame;
  logic [31:0] stat_snapshot;
  logic [5:0]  stat_clk_cnt;

  gamepad_dev #(
    .DATA_WIDTH (2),
    .SYNC_STAGES(2),
    .FILT_LEN   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .pad_data     (pad_data),
    .btn_value    (btn_value),
    .ctrl_en      (ctrl_en),
    .stat_frame   (stat_frame),
    .stat_snapshot(stat_snapshot),
    .stat_clk_cnt (stat_clk_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int frame_cnt = 0;

  always @(negedge clk) begin
    if (stat_frame === 1'b1) frame_cnt++;
  end

  typedef struct {
    logic [31:0] btn;
    int          nclk;
    logic [5:0]  exp_cnt;
    logic [1:0]  exp_pd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Line k sends ~btn bit idx for the first 16 rises, then released (1).
  function automatic logic [1:0] model_data(input logic [31:0] btn, input int idx);
    logic [1:0] r;
    for (int k = 0; k < 2; k++) begin
      if (idx < 16) r[k] = ~btn[16*k + idx];
      else          r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_pulse();
    pad_clk = 1'b0;
    wait_cyc(PH);
    pad_clk = 1'b1;
    wait_cyc(PH);
  endtask

  task automatic run_frame(input logic [31:0] btn, input int nclk, output logic [1:0] final_pd);
    int fc0;
    btn_value = btn;
    pad_latch = 1'b1;
    wait_cyc(PH);
    chk("live_load", pad_data, model_data(btn, 0));
    fc0 = frame_cnt;
    pad_latch = 1'b0;
    wait_cyc(PH);
    chk("frame_pulse", frame_cnt - fc0, 1);
    chk("clk_cnt_start", stat_clk_cnt, 0);
    btn_value = $urandom();  // snapshot must not follow later changes
    for (int i = 0; i < nclk; i++) begin
      chk($sformatf("bit%0d", i), pad_data, model_data(btn, i));
      clk_pulse();
    end
    chk("bit_end", pad_data, model_data(btn, nclk));
    chk("clk_cnt", stat_clk_cnt, (nclk > 63) ? 63 : nclk);
    chk("snapshot", stat_snapshot, btn);
    final_pd = pad_data;
  endtask

  initial begin
    logic [1:0]  pd;
    logic [31:0] rb;
    int          fc0;
    int          nc;

    tbl[0] = '{32'h8000_0005, 16, 6'd16, 2'b11};
    tbl[1] = '{32'h8000_0005, 20, 6'd20, 2'b11};
    tbl[2] = '{32'h8000_0005, 70, 6'd63, 2'b11};
    tbl[3] = '{32'h8000_0005,  2, 6'd2,  2'b10};
    tbl[4] = '{32'h8000_0005, 15, 6'd15, 2'b01};
    tbl[5] = '{32'h0001_0000,  0, 6'd0,  2'b01};
    tbl[6] = '{32'hFFFF_0000,  5, 6'd5,  2'b01};
    tbl[7] = '{32'h0000_0002,  1, 6'd1,  2'b10};

    rst_n     = 1'b0;
    pad_latch = 1'b0;
    pad_clk   = 1'b1;
    ctrl_en   = 1'b1;
    btn_value = '0;
    wait_cyc(4);
    chk("rst_pad_data", pad_data, 2'b11);
    chk("rst_frame", stat_frame, 1'b0);
    chk("rst_snapshot", stat_snapshot, 32'h0);
    chk("rst_clk_cnt", stat_clk_cnt, 6'd0);
    rst_n = 1'b1;
    wait_cyc(5);
    chk("idle_pad_data", pad_data, 2'b11);

    // Table frames, chained; entry 6 is aborted by entry 7's latch.
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].btn, tbl[i].nclk, pd);
      chk($sformatf("tbl%0d_pd", i), pd, tbl[i].exp_pd);
      chk($sformatf("tbl%0d_cnt", i), stat_clk_cnt, tbl[i].exp_cnt);
    end

    // Live tracking while latch is held; clocks under latch are ignored.
    btn_value = 32'h0;
    pad_latch = 1'b1;
    wait_cyc(PH);
    chk("hold_released", pad_data, 2'b11);
    btn_value = 32'h0000_0001;
    wait_cyc(1);
    chk("hold_track", pad_data, 2'b10);
    clk_pulse();
    chk("hold_clk_noshift", pad_data, 2'b10);
    chk("hold_clk_nocount", stat_clk_cnt, 6'd1);
    fc0 = frame_cnt;
    pad_latch = 1'b0;
    wait_cyc(PH);
    chk("hold_frame", frame_cnt - fc0, 1);
    chk("hold_cnt0", stat_clk_cnt, 6'd0);
    chk("hold_bit0", pad_data, 2'b10);

    // Clock glitches of 1 and 2 cycles are rejected, 3 cycles accepted.
    for (int g = 1; g <= 3; g++) begin
      pad_clk = 1'b0;
      wait_cyc(g);
      pad_clk = 1'b1;
      wait_cyc(PH);
      chk($sformatf("clk_glitch%0d_cnt", g), stat_clk_cnt, (g == 3) ? 1 : 0);
      chk($sformatf("clk_glitch%0d_pd", g), pad_data, (g == 3) ? 2'b11 : 2'b10);
    end

    // Latch glitches: 1 and 2 cycles ignored, 3 cycles reloads.
    for (int g = 1; g <= 3; g++) begin
      fc0 = frame_cnt;
      pad_latch = 1'b1;
      wait_cyc(g);
      pad_latch = 1'b0;
      wait_cyc(PH);
      chk($sformatf("lat_glitch%0d_frame", g), frame_cnt - fc0, (g == 3) ? 1 : 0);
      chk($sformatf("lat_glitch%0d_cnt", g), stat_clk_cnt, (g == 3) ? 0 : 1);
      chk($sformatf("lat_glitch%0d_pd", g), pad_data, (g == 3) ? 2'b10 : 2'b11);
    end

    // ctrl_en dropped mid-frame.
    btn_value = 32'hFFFF_FFFF;
    pad_latch = 1'b1;
    wait_cyc(PH);
    pad_latch = 1'b0;
    wait_cyc(PH);
    repeat (3) clk_pulse();
    chk("en_pre_pd", pad_data, 2'b00);
    ctrl_en = 1'b0;
    wait_cyc(2);
    chk("dis_pd", pad_data, 2'b11);
    chk("dis_cnt", stat_clk_cnt, 6'd3);
    chk("dis_snapshot", stat_snapshot, 32'hFFFF_FFFF);
    fc0 = frame_cnt;
    btn_value = 32'h1234_5678;
    repeat (2) clk_pulse();
    pad_latch = 1'b1;
    wait_cyc(PH);
    chk("dis_latch_pd", pad_data, 2'b11);
    pad_latch = 1'b0;
    wait_cyc(PH);
    chk("dis_frame", frame_cnt - fc0, 0);
    chk("dis_cnt_frozen", stat_clk_cnt, 6'd3);
    chk("dis_snap_frozen", stat_snapshot, 32'hFFFF_FFFF);
    ctrl_en = 1'b1;
    wait_cyc(2);
    run_frame(32'hA5A5_3C3C, 16, pd);
    chk("reen_pd", pd, 2'b11);

    // Asynchronous reset mid-shift.
    btn_value = 32'h0000_FFFF;
    pad_latch = 1'b1;
    wait_cyc(PH);
    pad_latch = 1'b0;
    wait_cyc(PH);
    repeat (4) clk_pulse();
    chk("prerst_pd", pad_data, 2'b10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pd", pad_data, 2'b11);
    chk("arst_cnt", stat_clk_cnt, 6'd0);
    chk("arst_snapshot", stat_snapshot, 32'h0);
    chk("arst_frame", stat_frame, 1'b0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    run_frame(32'h0F0F_F0F0, 10, pd);

    // Random frames, some of them aborted by the following latch.
    for (int r = 0; r < 12; r++) begin
      rb = $urandom();
      nc = $urandom_range(0, 24);
      run_frame(rb, nc, pd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
